fp16_norm_pack: RTL

- Sequential normalize-and-pack stage sitting directly downstream of the combinational FP16 adder.
- Accepts the adder's sign, biased exponent and 11-bit significand (hidden bit included, possibly denormalized after an effective subtraction).
- Left-normalizes one bit per cycle, detects zero/subnormal/infinity, and emits a packed IEEE-754 binary16 word over a valid/ready handshake.

---
 rtl/fp16_pkg.sv | 28 ++
 rtl/fp16_classify.sv | 43 ++++
 rtl/fp16_norm_pack.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the adder/multiplier back-end stages.
// Holds the field widths, special encodings, the pack-stage state enum and
// a helper that assembles a binary16 word from its three fields.
package fp16_pkg;

  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;
  localparam int unsigned BIAS  = 15;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

  localparam logic [15:0] POS_ZERO = 16'h0000;
  localparam logic [15:0] POS_INF  = 16'h7C00;
  localparam logic [15:0] NEG_INF  = 16'hFC00;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StDone
  } state_e;

  function automatic logic [15:0] fp16_pack(input logic             sign,
                                            input logic [EXP_W-1:0] exp,
                                            input logic [MAN_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp16_classify.sv
// Combinational classifier for a (biased exponent, significand) pair.
// Exactly one of the outputs is high, or none when another left shift is
// still needed. Decisions are resolved in priority order inf > zero >
// normal > subnormal.
// Ports:
//   exp        biased exponent under evaluation
//   mant       significand, bit MAN_W is the hidden bit
//   is_inf     exponent saturated
//   is_zero    significand is zero
//   is_normal  hidden bit set with a non-zero exponent
//   is_sub     cannot normalise further (exponent at 0 or 1)
module fp16_classify #(
  parameter int unsigned EXP_W = fp16_pkg::EXP_W,
  parameter int unsigned MAN_W = fp16_pkg::MAN_W
) (
  input  logic [EXP_W-1:0] exp,
  input  logic [MAN_W:0]   mant,
  output logic             is_inf,
  output logic             is_zero,
  output logic             is_normal,
  output logic             is_sub
);

  localparam logic [EXP_W-1:0] ExpOne = EXP_W'(1);

  always_comb begin
    is_inf    = 1'b0;
    is_zero   = 1'b0;
    is_normal = 1'b0;
    is_sub    = 1'b0;
    if (exp == '1) begin
      is_inf = 1'b1;
    end else if (mant == '0) begin
      is_zero = 1'b1;
    end else if (mant[MAN_W] && (exp != '0)) begin
      is_normal = 1'b1;
    end else if (exp <= ExpOne) begin
      // Also catches exp==0 with the hidden bit set.
      is_sub = 1'b1;
    end
  end

endmodule

// File: rtl/fp16_norm_pack.sv
// Sequential normalise-and-pack stage behind the FP16 adder.
// Left-normalises the significand one bit per cycle, classifies the result
// and presents a packed binary16 word over a valid/ready handshake.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake (ready only while idle)
//   in_sign/exp/mant  adder result fields, mant includes the hidden bit
//   out_valid/ready   result handshake
//   out_result        packed {sign, exp, frac}
//   out_zero/inf/sub  result class flags
//   out_shift_cnt     number of left shifts applied
module fp16_norm_pack #(
  parameter int unsigned EXP_W           = fp16_pkg::EXP_W,
  parameter int unsigned MAN_W           = fp16_pkg::MAN_W,
  parameter bit          FLUSH_SUBNORMAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W:0]   in_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic             out_zero,
  output logic             out_inf,
  output logic             out_sub,
  output logic [3:0]       out_shift_cnt
);

  import fp16_pkg::*;

  localparam logic [EXP_W-1:0] ExpOne = EXP_W'(1);

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [MAN_W:0]   mant_q, mant_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [15:0]      result_q, result_d;
  logic             zero_q, zero_d;
  logic             inf_q, inf_d;
  logic             sub_q, sub_d;

  logic is_inf, is_zero, is_normal, is_sub;

  fp16_classify #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_classify (
    .exp      (exp_q),
    .mant     (mant_q),
    .is_inf   (is_inf),
    .is_zero  (is_zero),
    .is_normal(is_normal),
    .is_sub   (is_sub)
  );

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    inf_d    = inf_q;
    sub_d    = sub_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          mant_d  = in_mant;
          cnt_d   = '0;
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (is_inf) begin
          result_d = sign_q ? NEG_INF : POS_INF;
          inf_d    = 1'b1;
          state_d  = StDone;
        end else if (is_zero) begin
          // Exact zero is always reported as +0.
          result_d = POS_ZERO;
          zero_d   = 1'b1;
          state_d  = StDone;
        end else if (is_normal) begin
          result_d = fp16_pack(sign_q, exp_q, mant_q[MAN_W-1:0]);
          state_d  = StDone;
        end else if (is_sub) begin
          if (FLUSH_SUBNORMAL) begin
            // Flushed subnormals keep their sign.
            result_d = fp16_pack(sign_q, '0, '0);
            zero_d   = 1'b1;
          end else begin
            result_d = fp16_pack(sign_q, '0, mant_q[MAN_W-1:0]);
            sub_d    = 1'b1;
          end
          state_d = StDone;
        end else begin
          // Classifier guarantees exp > 1 here, so no underflow.
          mant_d = {mant_q[MAN_W-1:0], 1'b0};
          exp_d  = exp_q - ExpOne;
          cnt_d  = cnt_q + 4'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          zero_d  = 1'b0;
          inf_d   = 1'b0;
          sub_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      inf_q    <= 1'b0;
      sub_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      inf_q    <= inf_d;
      sub_q    <= sub_d;
    end
  end

  assign in_ready      = (state_q == StIdle);
  assign out_valid     = (state_q == StDone);
  assign out_result    = result_q;
  assign out_zero      = zero_q;
  assign out_inf       = inf_q;
  assign out_sub       = sub_q;
  assign out_shift_cnt = cnt_q;

endmodule
